// File: rtl/fpu_pkg.sv
// Shared FPU types: IEEE-754 single field view, canonical special encodings
// and an operand classifier used by the multi-cycle FPU units.
package fpu_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
  } float_t;

  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [31:0] PINF = 32'h7F800000;

  typedef enum logic [2:0] {ZERO, DENORM, NORMAL, INF, NAN} fclass_t;

  function automatic fclass_t classify(input float_t f);
    if (f.exponent == 8'd0)
      return (f.mantissa == 23'd0) ? ZERO : DENORM;
    if (f.exponent == 8'hFF)
      return (f.mantissa == 23'd0) ? INF : NAN;
    return NORMAL;
  endfunction

endpackage

// File: rtl/fpu_result_fifo.sv
// Completion FIFO holding tag + data + flag per result; circular buffer with
// a combinational head view, flush, and simultaneous push/pop at any level.
module fpu_result_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic [TAG_W-1:0]           push_tag,
  input  logic                       push_flag,
  input  logic                       pop,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic [TAG_W-1:0]           out_tag,
  output logic                       out_flag,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = DATA_W + TAG_W + 1;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push, do_pop;
  logic [ENT_W-1:0] head;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop  = pop && (count_reg != '0);
  assign do_push = push && ((count_reg != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr_reg] <= {push_tag, push_data, push_flag};
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wrap_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= wrap_inc(rd_ptr_reg);
      if (do_push && !do_pop)      count_reg <= count_reg + CNT_W'(1);
      else if (do_pop && !do_push) count_reg <= count_reg - CNT_W'(1);
    end
  end

  // Outputs read as zero when empty, so stale storage never shows.
  assign head      = mem[rd_ptr_reg];
  assign out_valid = (count_reg != '0);
  assign out_tag   = out_valid ? head[ENT_W-1 -: TAG_W] : '0;
  assign out_data  = out_valid ? head[DATA_W:1] : '0;
  assign out_flag  = out_valid ? head[0] : 1'b0;
  assign count     = count_reg;

endmodule

// File: rtl/fsqrt.sv
// Combinational single-precision square root for positive normal operands,
// digit-by-digit integer root of the aligned significand, round to nearest.
module fsqrt (
  input  logic [30:0] x,
  output logic [31:0] y
);

  logic [47:0] rad;
  logic [27:0] rem;
  logic [27:0] trial;
  logic [23:0] root;
  logic [22:0] mant;

  always_comb begin
    // An odd unbiased exponent (even biased field) folds one extra factor of 2
    // into the radicand so the exponent halves exactly.
    rad = x[23] ? {1'b0, 1'b1, x[22:0], 23'b0} : {1'b1, x[22:0], 24'b0};
    rem  = '0;
    root = '0;
    for (int i = 23; i >= 0; i--) begin
      rem   = {rem[25:0], rad[2*i +: 2]};
      trial = {2'b00, root, 2'b01};
      if (rem >= trial) begin
        rem  = rem - trial;
        root = {root[22:0], 1'b1};
      end else begin
        root = {root[22:0], 1'b0};
      end
    end
    // Remainder above the root means the true value lies past root+0.5.
    mant = (rem > {4'b0, root}) ? root[22:0] + 23'd1 : root[22:0];
    y    = {1'b0, 8'(({1'b0, x[30:23]} + 9'd127) >> 1), mant};
  end

endmodule

// File: rtl/fsqrt_pipe_ctrl.sv
// Square-root issue/completion stage: credit-gated acceptance, special-operand
// bypass, fixed-depth retiming pipeline and a completion FIFO for writeback.
module fsqrt_pipe_ctrl
  import fpu_pkg::*;
#(
  parameter int TAG_W      = 6,
  parameter int STAGES     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_x,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_invalid
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH + STAGES + 1);
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

  logic             valid_reg [STAGES];
  logic [TAG_W-1:0] tag_reg   [STAGES];
  logic [31:0]      data_reg  [STAGES];
  logic             inv_reg   [STAGES];

  logic [CNT_W-1:0]  inflight;
  logic [FCNT_W-1:0] fifo_count;
  logic              accept;
  logic [31:0]       fsqrt_y;
  logic [31:0]       sel_data;
  logic              sel_inv;
  float_t            op;
  fclass_t           op_class;
  logic              push;
  logic [31:0]       push_data;
  logic [TAG_W-1:0]  push_tag;
  logic              push_inv;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < STAGES; i++)
      inflight = inflight + CNT_W'(valid_reg[i]);
  end

  // Credits use registered occupancy only, so a pop frees its slot next cycle.
  assign in_ready = !rst && !flush &&
                    ((inflight + CNT_W'(fifo_count)) < CNT_W'(FIFO_DEPTH));
  assign accept   = in_valid && in_ready;

  fsqrt u_fsqrt (
    .x (data_reg[0][30:0]),
    .y (fsqrt_y)
  );

  always_comb begin
    op       = float_t'(data_reg[0]);
    op_class = classify(op);
    sel_data = fsqrt_y;
    sel_inv  = 1'b0;
    if (op_class == NAN) begin
      sel_data = QNAN;
    end else if (op.sign && op_class != ZERO) begin
      sel_data = QNAN;
      sel_inv  = 1'b1;
    end else if (op_class == ZERO || op_class == DENORM) begin
      sel_data = {op.sign, 31'b0};
    end else if (op_class == INF) begin
      sel_data = PINF;
    end
  end

  genvar gi;
  for (gi = 0; gi < STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_capture
      always_ff @(posedge clk) begin
        valid_reg[gi] <= (rst || flush) ? 1'b0 : accept;
        inv_reg[gi]   <= 1'b0;
        if (accept) begin
          data_reg[gi] <= in_x;
          tag_reg[gi]  <= in_tag;
        end
      end
    end else begin : g_retime
      always_ff @(posedge clk) begin
        valid_reg[gi] <= (rst || flush) ? 1'b0 : valid_reg[gi-1];
        tag_reg[gi]   <= tag_reg[gi-1];
        data_reg[gi]  <= (gi == 1) ? sel_data : data_reg[gi-1];
        inv_reg[gi]   <= (gi == 1) ? sel_inv : inv_reg[gi-1];
      end
    end
  end

  if (STAGES == 1) begin : g_push_direct
    assign push_data = sel_data;
    assign push_inv  = sel_inv;
  end else begin : g_push_piped
    assign push_data = data_reg[STAGES-1];
    assign push_inv  = inv_reg[STAGES-1];
  end
  assign push     = valid_reg[STAGES-1];
  assign push_tag = tag_reg[STAGES-1];

  fpu_result_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (32),
    .TAG_W  (TAG_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (push_data),
    .push_tag  (push_tag),
    .push_flag (push_inv),
    .pop       (out_ready),
    .out_valid (out_valid),
    .out_data  (out_y),
    .out_tag   (out_tag),
    .out_flag  (out_invalid),
    .count     (fifo_count)
  );

endmodule
